// File: rtl/conv_window_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : conv_window_sequencer
// Description : Walks every KxK valid-padding window of an image frame held in
//               a simple-dual-port RAM and streams each pixel (raw and
//               binarized) to the conv engine over valid/ready.
// Revision    : 1.0 - initial release
// =============================================================================
module conv_window_sequencer #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int THRESH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ram_ce_o,
  output logic [ADDR_W-1:0] ram_adb_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              pix_bin_o,
  output logic              win_last_o,
  output logic [4:0]        win_row_o,
  output logic [4:0]        win_col_o
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = 5;
  localparam logic [KW-1:0]     K_LAST   = KW'(K - 1);
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - K);
  localparam logic [CW-1:0]     ROW_LAST = CW'(IMG_H - K);
  localparam logic [DATA_W-1:0] THR      = DATA_W'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       orow_q, orow_d, ocol_q, ocol_d;
  logic [KW-1:0]       kr_q, kr_d, kc_q, kc_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                bin_q, bin_d, last_q, last_d;
  logic [CW-1:0]       wrow_q, wrow_d, wcol_q, wcol_d;

  logic [ADDR_W-1:0]   w_row_sum;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_k_end;
  logic                w_frame_end;

  // Address is derived from the live counters, so it stays put while OUT stalls.
  assign w_row_sum   = ADDR_W'(orow_q) + ADDR_W'(kr_q);
  assign w_addr      = w_row_sum * ADDR_W'(IMG_W) + ADDR_W'(ocol_q) + ADDR_W'(kc_q);
  assign w_k_end     = (kr_q == K_LAST) && (kc_q == K_LAST);
  assign w_frame_end = w_k_end && (ocol_q == COL_LAST) && (orow_q == ROW_LAST);

  always_comb begin
    state_d = state_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    bin_d   = bin_q;
    last_d  = last_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          orow_d  = '0;
          ocol_d  = '0;
          kr_d    = '0;
          kc_d    = '0;
          busy_d  = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        data_d  = ram_dout_i;
        bin_d   = (ram_dout_i >= THR);
        last_d  = w_k_end;
        wrow_d  = orow_q;
        wcol_d  = ocol_q;
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (pix_ready_i) begin
          valid_d = 1'b0;
          if (w_frame_end) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_RD;
            if (kc_q != K_LAST) begin
              kc_d = kc_q + 1'b1;
            end else begin
              kc_d = '0;
              if (kr_q != K_LAST) begin
                kr_d = kr_q + 1'b1;
              end else begin
                kr_d = '0;
                if (ocol_q != COL_LAST) begin
                  ocol_d = ocol_q + 1'b1;
                end else begin
                  ocol_d = '0;
                  orow_d = orow_q + 1'b1;
                end
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything else in any active state.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      orow_d  = '0;
      ocol_d  = '0;
      kr_d    = '0;
      kc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      orow_q  <= '0;
      ocol_q  <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      bin_q   <= 1'b0;
      last_q  <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
    end else begin
      state_q <= state_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      bin_q   <= bin_d;
      last_q  <= last_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
    end
  end

  assign ram_ce_o    = (state_q == S_RD);
  assign ram_adb_o   = w_addr;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pix_valid_o = valid_q;
  assign pix_data_o  = data_q;
  assign pix_bin_o   = bin_q;
  assign win_last_o  = last_q;
  assign win_row_o   = wrow_q;
  assign win_col_o   = wcol_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : tb_conv_window_sequencer
// Description : Self-checking bench; pixel stream compared against a window
//               list built directly from the frame contents.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_conv_window_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, pix_ready;
  logic       busy, done, ram_ce, pix_valid, pix_bin, win_last;
  logic [9:0] ram_adb;
  logic [7:0] ram_dout, pix_data;
  logic [4:0] win_row, win_col;

  always #5 clk = ~clk;

  conv_window_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .busy_o     (busy),
    .done_o     (done),
    .ram_ce_o   (ram_ce),
    .ram_adb_o  (ram_adb),
    .ram_dout_i (ram_dout),
    .pix_valid_o(pix_valid),
    .pix_ready_i(pix_ready),
    .pix_data_o (pix_data),
    .pix_bin_o  (pix_bin),
    .win_last_o (win_last),
    .win_row_o  (win_row),
    .win_col_o  (win_col)
  );

  // Image RAM read port: registered read, data valid the cycle after ce.
  logic [7:0] mem [0:1023];
  logic [7:0] ram_q;
  always @(posedge clk) if (ram_ce) ram_q <= mem[ram_adb];
  assign ram_dout = ram_q;

  typedef struct {
    int         addr;
    int         row;
    int         col;
    int         kr;
    int         kc;
    bit         last;
    logic [7:0] data;
  } pix_t;

  pix_t exp_q[$];
  int   obs_addr[$];
  int   n_pass = 0, n_total = 0;
  int   hs, last_cnt, done_cnt, last_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic build_frame();
    pix_t e;
    exp_q.delete();
    for (int r = 0; r <= 25; r++)
      for (int c = 0; c <= 25; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            e.addr = (r + i) * 28 + c + j;
            e.row  = r;
            e.col  = c;
            e.kr   = i;
            e.kc   = j;
            e.last = (i == 2) && (j == 2);
            e.data = mem[e.addr];
            exp_q.push_back(e);
          end
  endtask

  // One clock: check visible outputs, choose pix_ready, advance the model.
  task automatic mon_cycle(input int mode);
    pix_t e;
    if (ram_ce) begin
      obs_addr.push_back(int'(ram_adb));
      last_addr = int'(ram_adb);
      if (exp_q.size() > 0) chk("rd_addr", ram_adb, exp_q[0].addr);
      else chk("rd_extra", exp_q.size(), 1);
    end
    if (pix_valid) begin
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("pix_data", pix_data, e.data);
        chk("pix_bin", pix_bin, (e.data >= 8'd128));
        chk("win_last", win_last, e.last);
        chk("win_row", win_row, e.row);
        chk("win_col", win_col, e.col);
        if (e.row == 3 && e.col == 9 && e.kr == 2 && e.kc == 2) begin
          chk("bin151_adb", ram_adb, 151);
          chk("bin151_data", pix_data, 8'hE0);
          chk("bin151_bin", pix_bin, 1);
        end
        if (e.row == 5 && e.col == 17 && e.kr == 0 && e.kc == 2) begin
          chk("bin159_adb", ram_adb, 159);
          chk("bin159_data", pix_data, 8'h46);
          chk("bin159_bin", pix_bin, 0);
        end
      end else begin
        chk("pix_extra", exp_q.size(), 1);
      end
    end
    case (mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (pix_valid && pix_ready) begin
      if (exp_q.size() > 0) begin
        if (exp_q[0].last) last_cnt++;
        void'(exp_q.pop_front());
      end
      hs++;
    end
    if (done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_pass();
    build_frame();
    obs_addr.delete();
    hs       = 0;
    last_cnt = 0;
    done_cnt = 0;
    start    = 1'b1;
    mon_cycle(1);
    start    = 1'b0;
  endtask

  logic [63:0] outs;
  int          lat, g;
  int          first_tbl [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};

  always_comb outs = {30'd0, busy, done, ram_ce, ram_adb, pix_valid, pix_data,
                      pix_bin, win_last, win_row, win_col};

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[151] = 8'hE0;
    mem[159] = 8'h46;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First window and start-to-valid latency.
    begin_pass();
    lat = 1;
    while (!pix_valid && lat < 10) begin
      mon_cycle(1);
      lat++;
    end
    chk("first_valid_lat", lat, 3);
    g = 0;
    while (hs < 9 && g < 200) begin mon_cycle(1); g++; end
    for (int i = 0; i < 9; i++)
      if (obs_addr.size() > i) chk("first_win_adb", obs_addr[i], first_tbl[i]);
    chk("first_win_reads", obs_addr.size(), 9);
    chk("first_win_last", last_cnt, 1);

    // Rest of the frame with random backpressure.
    g = 0;
    while (done_cnt == 0 && g < 60000) begin mon_cycle(2); g++; end
    repeat (5) mon_cycle(2);
    chk("frame_hs", hs, 6084);
    chk("frame_last", last_cnt, 676);
    chk("frame_last_adb", last_addr, 783);
    chk("frame_done", done_cnt, 1);
    chk("frame_busy", busy, 0);
    chk("frame_left", exp_q.size(), 0);

    // Backpressure: 10 stalled cycles in OUT.
    begin_pass();
    g = 0;
    while (!pix_valid && g < 10) begin mon_cycle(0); g++; end
    repeat (10) begin
      chk("bp_valid", pix_valid, 1);
      chk("bp_ce", ram_ce, 0);
      chk("bp_adb", ram_adb, exp_q[0].addr);
      chk("bp_data", pix_data, exp_q[0].data);
      mon_cycle(0);
    end
    chk("bp_no_adv", hs, 0);

    // Start while busy is ignored; abort at pixel 100.
    g = 0;
    while (hs < 50 && g < 2000) begin mon_cycle(2); g++; end
    start = 1'b1;
    mon_cycle(2);
    start = 1'b0;
    g = 0;
    while (hs < 100 && g < 2000) begin mon_cycle(2); g++; end
    chk("abort_at_hs", hs, 100);
    abort = 1'b1;
    start = 1'b1;
    mon_cycle(1);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", pix_valid, 0);
    chk("abort_ce", ram_ce, 0);
    repeat (4) mon_cycle(1);
    chk("abort_done", done_cnt, 0);
    chk("abort_idle", busy, 0);

    // Start and abort together while idle: stays idle.
    start = 1'b1;
    abort = 1'b1;
    mon_cycle(1);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_idle_busy", busy, 0);
    chk("sa_idle_ce", ram_ce, 0);
    mon_cycle(1);
    chk("sa_idle_busy2", busy, 0);

    // Restart after abort begins at address 0.
    begin_pass();
    g = 0;
    while (hs < 20 && g < 2000) begin mon_cycle(2); g++; end
    chk("restart_first_adb", (obs_addr.size() > 0) ? obs_addr[0] : -1, 0);
    chk("restart_no_done", done_cnt, 0);

    // Asynchronous reset mid-pass with pix_valid high.
    g = 0;
    while (!pix_valid && g < 10) begin mon_cycle(0); g++; end
    chk("pre_reset_valid", pix_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", outs, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin_pass();
    g = 0;
    while (hs < 9 && g < 200) begin mon_cycle(1); g++; end
    chk("post_reset_adb", (obs_addr.size() > 0) ? obs_addr[0] : -1, 0);
    chk("post_reset_hs", hs, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
Controller that sequences reads from the 1024x8 simple-dual-port image RAM. The RAM holds one 28x28 8-bit input frame at addresses 0..783, row-major. For each KxK convolution window (valid padding, stride 1) the block issues read addresses on the RAM read port. It captures each returned byte, binarizes it against a threshold, and streams the pixels to the binary conv engine over a valid/ready interface. It sits between the image RAM read port and the first BCNN layer.

Parameters:
IMG_W, 28, frame width in pixels
IMG_H, 28, frame height in pixels
K, 3, window size (KxK)
ADDR_W, 10, RAM address width
DATA_W, 8, pixel width
THRESH, 128, binarization threshold; pix_bin = (pixel >= THRESH)

Ports:
clk  in  1  system clock; also drives RAM read clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a frame pass when idle
abort  in  1  level; terminates the pass and returns to IDLE
busy  out  1  high from accepted start until done/abort
done  out  1  one-cycle pulse after the last pixel handshake
ram_ce  out  1  RAM read clock-enable (ceb)
ram_adb  out  ADDR_W  RAM read address (adb)
ram_dout  in  DATA_W  RAM read data; valid the cycle after ram_ce/ram_adb are sampled
pix_valid  out  1  output pixel valid
pix_ready  in  1  downstream ready
pix_data  out  DATA_W  raw pixel
pix_bin  out  1  binarized pixel
win_last  out  1  marks the final pixel (kr=K-1, kc=K-1) of a window
win_row  out  5  output-window row index (orow)
win_col  out  5  output-window column index (ocol)

Behaviour:
- Reset (async, rst_n=0): all outputs 0. State IDLE; counters orow, ocol, kr, kc cleared.
- FSM states: IDLE, RD, CAP, OUT.
- IDLE: start=1 -> clear counters, busy<=1, go to RD. start is ignored outside IDLE.
- RD: ram_ce=1; ram_adb=(orow+kr)*IMG_W+(ocol+kc). Go to CAP. ram_ce is 0 in every other state.
- CAP: register ram_dout into pix_data, compute pix_bin, set win_last/win_row/win_col. pix_valid<=1, go to OUT.
- OUT: hold pix_valid and all pix_* and win_* stable until pix_ready=1.
  - On handshake: pix_valid<=0 and advance counters.
  - Counter order: kc fastest, then kr, then ocol, then orow.
  - kc wraps at K-1; kr wraps at K-1; ocol wraps at IMG_W-K; orow ends at IMG_H-K.
  - If the handshaken pixel was the last of the frame (orow=IMG_H-K, ocol=IMG_W-K, kr=kc=K-1): done<=1 for one cycle, busy<=0, go to IDLE. Otherwise go to RD.
- Throughput: 3 cycles per pixel at pix_ready=1; first pix_valid appears 3 cycles after the start edge.
- Frame totals (defaults): 26x26=676 windows, 6084 pixels, 676 win_last pulses.
- Address arithmetic: computed at ADDR_W bits; never exceeds IMG_W*IMG_H-1 (783). The multiply may be replaced by an incremental row-base register; the result must be identical.
- abort=1 in any non-IDLE state: next edge -> IDLE, pix_valid=0, ram_ce=0, busy=0, done stays 0, counters cleared. abort has priority over handshake and start.
- start and abort asserted in the same cycle while IDLE: stay IDLE.
- pix_ready asserted while pix_valid=0 has no effect.
- The block never writes the RAM; the write port belongs to the frame loader.

Test Plan:
- Reset: assert rst_n=0 mid-pass with pix_valid=1 -> all outputs 0 immediately (no clock edge needed); start after release begins at orow=ocol=0.
- First window: start, pix_ready=1 -> ram_adb sequence 0,1,2,28,29,30,56,57,58; win_last=1 only on the 9th pixel; win_row=win_col=0.
- Binarization with the preloaded frame: window orow=3, ocol=9, pixel kr=2, kc=2 -> address 151, pix_data=0xE0, pix_bin=1. Window orow=5, ocol=17, kr=0, kc=2 -> address 159, pix_data=0x46, pix_bin=0.
- Backpressure: hold pix_ready=0 for 10 cycles in OUT -> pix_valid, pix_data and ram_adb stable, ram_ce=0 throughout, no counter advance.
- Full frame with random pix_ready -> exactly 6084 handshakes, 676 win_last pulses, last ram_adb=783, one done pulse, then busy=0.
- Abort at pixel 100; a start pulse while busy is ignored; a start after abort begins again at address 0 with no done pulse from the aborted pass.
